mul_exp_pipe: RTL

MUL_EXP_PIPE -- requirements
Module: mul_exp_pipe

---
 rtl/mul_exp_pipe_pkg.sv | 17 +
 rtl/mul_exp_pipe.sv | 110 +++++++++++
 2 files changed

// File: rtl/mul_exp_pipe_pkg.sv
// Types and helpers for the floating-point multiplier exponent path.
// The FPU_MUL top reuses them.
package mul_exp_pipe_pkg;

    typedef enum logic [2:0] {
        FLAG_NORM = 3'd0,
        FLAG_ZERO = 3'd1,
        FLAG_INF  = 3'd2,
        FLAG_OVF  = 3'd3,
        FLAG_UNF  = 3'd4
    } flag_e;

    function automatic int default_bias(input int size_exp);
        return (1 << (size_exp - 1)) - 1;
    endfunction

endpackage

// File: rtl/mul_exp_pipe.sv
// Two-stage valid/ready pipeline for the exponent of a floating-point product.
// Stage 1 adds the exponents and classifies the operands. Stage 2 saturates the result and sets the status flags.
module mul_exp_pipe
    import mul_exp_pipe_pkg::*;
#(
    parameter int SIZE_EXP = 8,
    parameter int BIAS     = default_bias(SIZE_EXP)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_in_ready,
    input  logic [SIZE_EXP-1:0] i_exp_a,
    input  logic [SIZE_EXP-1:0] i_exp_b,
    input  logic                i_mant_carry,
    output logic                o_valid,
    input  logic                i_out_ready,
    output logic [SIZE_EXP-1:0] o_exp,
    output logic                o_ovf,
    output logic                o_unf,
    output logic                o_zero,
    output logic                o_inf
);

    localparam int SW = SIZE_EXP + 2;
    localparam logic signed [SW-1:0] BIAS_S = SW'(BIAS);
    localparam logic signed [SW-1:0] OVF_TH = SW'((1 << SIZE_EXP) - 1);

    logic                 s1_adv, s2_adv;
    logic signed [SW-1:0] sum_c;
    logic                 zero_c, inf_c;
    logic                 vld_p1, zero_p1, inf_p1;
    logic signed [SW-1:0] sum_p1;
    flag_e                flag_c;
    logic [SIZE_EXP-1:0]  exp_c;

    function automatic flag_e classify(input logic zero, input logic inf,
                                       input logic signed [SW-1:0] sum);
        if (zero)
            return FLAG_ZERO;
        if (inf)
            return FLAG_INF;
        if (sum >= OVF_TH)
            return FLAG_OVF;
        if (sum[SW-1] || (sum == '0))
            return FLAG_UNF;
        return FLAG_NORM;
    endfunction

    function automatic logic [SIZE_EXP-1:0] saturate(input flag_e flag,
                                                      input logic signed [SW-1:0] sum);
        case (flag)
            FLAG_ZERO, FLAG_UNF: return '0;
            FLAG_INF, FLAG_OVF:  return '1;
            default:             return sum[SIZE_EXP-1:0];
        endcase
    endfunction

    assign s2_adv     = !o_valid || i_out_ready;
    assign s1_adv     = !vld_p1 || s2_adv;
    // Reset forces ready high, but the capture below is still blocked while reset is active.
    assign o_in_ready = i_rst || s1_adv;

    always_comb begin
        sum_c  = $signed({2'b00, i_exp_a}) + $signed({2'b00, i_exp_b})
               + $signed({{(SW-1){1'b0}}, i_mant_carry}) - BIAS_S;
        zero_c = (i_exp_a == '0) || (i_exp_b == '0);
        inf_c  = !zero_c && ((i_exp_a == '1) || (i_exp_b == '1));
        flag_c = classify(zero_p1, inf_p1, sum_p1);
        exp_c  = saturate(flag_c, sum_p1);
    end

    // Stage 1: exponent sum and operand classification
    always_ff @(posedge i_clk) begin
        if (i_rst)
            vld_p1 <= 1'b0;
        else if (s1_adv)
            vld_p1 <= i_valid;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && s1_adv && i_valid) begin
            sum_p1  <= sum_c;
            zero_p1 <= zero_c;
            inf_p1  <= inf_c;
        end
    end

    // Stage 2: saturated exponent and status flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_exp   <= '0;
            o_zero  <= 1'b0;
            o_inf   <= 1'b0;
            o_ovf   <= 1'b0;
            o_unf   <= 1'b0;
        end else if (s2_adv) begin
            o_valid <= vld_p1;
            if (vld_p1) begin
                o_exp  <= exp_c;
                o_zero <= (flag_c == FLAG_ZERO);
                o_inf  <= (flag_c == FLAG_INF);
                o_ovf  <= (flag_c == FLAG_OVF);
                o_unf  <= (flag_c == FLAG_UNF);
            end
        end
    end

endmodule
